// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types and limits for the serial shift controller.
// Related build option: SISO_SHIFT_CTRL_PARITY_EN (see siso_shift_ctrl.sv).
package siso_shift_ctrl_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MIN_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/siso_shift_ctrl_sreg.sv
// WIDTH-bit load/shift register; head is the next bit to leave, chosen by MSB_FIRST.
// Each shift moves the remaining bits toward the head and fills the tail with zero.
module siso_shift_ctrl_sreg
    import siso_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             head
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign q_shifted = {q[WIDTH-2:0], 1'b0};
            assign head      = q[WIDTH-1];
        end else begin : g_lsb
            assign q_shifted = {1'b0, q[WIDTH-1:1]};
            assign head      = q[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q_shifted;
        end
    end

endmodule

// File: rtl/siso_shift_ctrl.sv
// Word-to-serial shift controller: valid/ready word intake, one bit per shift_en tick on so.
// Build option SISO_SHIFT_CTRL_PARITY_EN appends an even-parity bit via the PARITY state.
//
// state  | meaning
// IDLE   | waiting for a word; in_ready high
// SHIFT  | emitting data bits, one per shift_en
// PARITY | emitting the parity bit on the next shift_en (parity builds only)
// DONE   | one-cycle done pulse, then back to IDLE
module siso_shift_ctrl
    import siso_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    input  logic             abort,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             do_shift;
    logic             do_par;
    logic             head;

    siso_shift_ctrl_sreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (do_shift),
        .d     (in_data),
        .head  (head)
    );

`ifdef SISO_SHIFT_CTRL_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= even_parity(MAX_WIDTH'(in_data));
        end
    end
`endif

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        do_shift = 1'b0;
        do_par   = 1'b0;
        case (state)
            IDLE: begin
                // abort in IDLE suppresses an accept in the same cycle
                if (in_valid && !abort) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (shift_en) begin
                    do_shift = 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            PARITY: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (shift_en) begin
                    do_par  = 1'b1;
                    state_n = DONE;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
        end else begin
            state    <= state_n;
            so_valid <= do_shift | do_par;
            if (load) begin
                cnt <= '0;
            end else if (do_shift && cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (do_shift) begin
                so <= head;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            end else if (do_par) begin
                so <= par_q;
`endif
            end
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign done     = (state == DONE);

endmodule
